// File: rtl/qiantang_pkg.sv
// Shared decode definitions for the qiantang pipeline: instruction-class
// encodings carried in ctrl[6:3] and the write-back enable decode.
package qiantang_pkg;

    localparam int REG_WIDTH = 64;

    typedef enum logic [3:0] {
        CTRL_ARITHMETIC_R_00 = 4'd0,
        CTRL_ARITHMETIC_R_01 = 4'd1,
        CTRL_ARITHMETIC_R_10 = 4'd2,
        CTRL_ARITHMETIC_I_0  = 4'd3,
        CTRL_ARITHMETIC_I_1  = 4'd4,
        CTRL_ACCESS_I        = 4'd5,
        CTRL_ACCESS_S        = 4'd6,
        CTRL_BRANCH_B        = 4'd7,
        CTRL_JAL             = 4'd8,
        CTRL_JALR            = 4'd9,
        CTRL_LUI             = 4'd10,
        CTRL_AUIPC           = 4'd11,
        CTRL_CSR             = 4'd12,
        CTRL_ECALL           = 4'd13
    } ctrl_class_e;

    function automatic logic wb_writes(input logic [3:0] cls);
        logic wr;
        wr = 1'b0;
        case (cls)
            CTRL_ARITHMETIC_R_00, CTRL_ARITHMETIC_R_01, CTRL_ARITHMETIC_R_10,
            CTRL_ARITHMETIC_I_0, CTRL_ARITHMETIC_I_1, CTRL_ACCESS_I,
            CTRL_JAL, CTRL_JALR, CTRL_LUI, CTRL_AUIPC: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/wb_arbiter_stage_if.sv
// Bus bundle for the write-back stage: main pipeline input, long-latency
// input, register-file write port, forwarding outputs and status.
interface wb_arbiter_stage_if #(
    parameter int XLEN     = 64,
    parameter int CTRL_W   = 8,
    parameter int LL_DEPTH = 4
);
    logic                      main_valid_i;
    logic                      main_ready_o;
    logic [XLEN-1:0]           main_result_i;
    logic [4:0]                main_rd_i;
    logic [CTRL_W-1:0]         main_ctrl_i;
    logic                      main_fwd_ena_i;
    logic                      flush_i;
    logic                      ll_valid_i;
    logic                      ll_ready_o;
    logic [XLEN-1:0]           ll_result_i;
    logic [4:0]                ll_rd_i;
    logic                      rf_wen_o;
    logic [4:0]                rf_addr_o;
    logic [XLEN-1:0]           rf_data_o;
    logic                      fwd_ena_o;
    logic [4:0]                fwd_addr_o;
    logic [XLEN-1:0]           fwd_data_o;
    logic                      ecall_o;
    logic [$clog2(LL_DEPTH):0] ll_count_o;

    modport slave (
        input  main_valid_i, main_result_i, main_rd_i, main_ctrl_i, main_fwd_ena_i,
               flush_i, ll_valid_i, ll_result_i, ll_rd_i,
        output main_ready_o, ll_ready_o, rf_wen_o, rf_addr_o, rf_data_o,
               fwd_ena_o, fwd_addr_o, fwd_data_o, ecall_o, ll_count_o
    );

    modport master (
        output main_valid_i, main_result_i, main_rd_i, main_ctrl_i, main_fwd_ena_i,
               flush_i, ll_valid_i, ll_result_i, ll_rd_i,
        input  main_ready_o, ll_ready_o, rf_wen_o, rf_addr_o, rf_data_o,
               fwd_ena_o, fwd_addr_o, fwd_data_o, ecall_o, ll_count_o
    );
endinterface

// File: rtl/wb_ll_fifo.sv
// Holding FIFO for long-latency results ({rd, data}); power-of-two depth so
// the pointers wrap naturally.
module wb_ll_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o   = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rdata_o  = mem_q[rd_ptr_q];
        count_o  = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push && rst_n_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Write-back stage: arbitrates the in-order result and buffered long-latency
// results onto the single register-file write port, with starvation relief.
module wb_arbiter_stage
    import qiantang_pkg::*;
#(
    parameter int XLEN         = REG_WIDTH,
    parameter int CTRL_W       = 8,
    parameter int LL_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic              clk_sys_i,
    input logic              rst_sys_n_i,
    wb_arbiter_stage_if.slave bus
);
    localparam int ENTRY_W  = XLEN + 5;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [ENTRY_W-1:0]          fifo_head;
    logic [$clog2(LL_DEPTH):0]   fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;

    logic                        starve;
    logic                        main_fire;
    logic                        main_wr;

    logic [STARVE_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic                        rf_wen_q, rf_wen_d;
    logic [4:0]                  rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]             rf_data_q, rf_data_d;
    logic                        fwd_ena_q, fwd_ena_d;
    logic                        ecall_q, ecall_d;

    logic                        unused_ctrl_bits;
    assign unused_ctrl_bits = ^{bus.main_ctrl_i[CTRL_W-1:7], bus.main_ctrl_i[2:0]};

    wb_ll_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LL_DEPTH)
    ) u_ll_fifo (
        .clk_i   (clk_sys_i),
        .rst_n_i (rst_sys_n_i),
        .push_i  (fifo_push),
        .wdata_i ({bus.ll_rd_i, bus.ll_result_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        starve    = (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) && !fifo_empty;
        bus.main_ready_o = rst_sys_n_i && !starve;
        bus.ll_ready_o   = rst_sys_n_i && !fifo_full;
        fifo_push = bus.ll_valid_i && bus.ll_ready_o;
        main_fire = bus.main_valid_i && bus.main_ready_o && !bus.flush_i;
        main_wr   = main_fire && wb_writes(bus.main_ctrl_i[6:3]) && (bus.main_rd_i != 5'd0);
        // A non-writing accepted instruction leaves the port to the FIFO.
        fifo_pop  = !main_wr && !fifo_empty;

        rf_wen_d     = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        fwd_ena_d    = 1'b0;
        starve_cnt_d = '0;
        ecall_d      = main_fire && (bus.main_ctrl_i[6:3] == CTRL_ECALL);

        if (main_wr) begin
            rf_wen_d  = 1'b1;
            rf_addr_d = bus.main_rd_i;
            rf_data_d = bus.main_result_i;
            fwd_ena_d = bus.main_fwd_ena_i;
            if (!fifo_empty) begin
                starve_cnt_d = (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) ?
                               starve_cnt_q : starve_cnt_q + STARVE_W'(1);
            end
        end else if (fifo_pop) begin
            rf_wen_d  = 1'b1;
            rf_addr_d = fifo_head[ENTRY_W-1:XLEN];
            rf_data_d = fifo_head[XLEN-1:0];
            fwd_ena_d = 1'b1;
        end else if (!fifo_empty) begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_n_i) begin
            starve_cnt_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            fwd_ena_q    <= 1'b0;
            ecall_q      <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            fwd_ena_q    <= fwd_ena_d;
            ecall_q      <= ecall_d;
        end
    end

    assign bus.rf_wen_o   = rf_wen_q;
    assign bus.rf_addr_o  = rf_addr_q;
    assign bus.rf_data_o  = rf_data_q;
    assign bus.fwd_ena_o  = fwd_ena_q;
    assign bus.fwd_addr_o = rf_addr_q;
    assign bus.fwd_data_o = rf_data_q;
    assign bus.ecall_o    = ecall_q;
    assign bus.ll_count_o = fifo_count;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Bench for wb_arbiter_stage: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based model of the write-back rules.
module tb_wb_arbiter_stage;
    import qiantang_pkg::*;

    localparam int XLEN = 64;
    localparam int CTRL_W = 8;
    localparam int LL_DEPTH = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk_sys_i = 1'b0;
    logic rst_sys_n_i;
    always #5 clk_sys_i = ~clk_sys_i;

    wb_arbiter_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .LL_DEPTH(LL_DEPTH)) bus ();

    wb_arbiter_stage #(
        .XLEN(XLEN), .CTRL_W(CTRL_W), .LL_DEPTH(LL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_sys_n_i (rst_sys_n_i),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: pending long-latency entries and the expected registered outputs.
    logic [68:0]     ll_q[$];
    int              m_starve = 0;
    logic            e_wen = 0, e_fen = 0, e_ecall = 0;
    logic [4:0]      e_addr = 0;
    logic [63:0]     e_data = 0;
    logic            last_main_acc = 0, last_ll_acc = 0;

    function automatic logic class_writes(input logic [3:0] cls);
        return (cls <= 4'd5) || (cls >= 4'd8 && cls <= 4'd11);
    endfunction

    task automatic do_cycle(input logic rst_n, input logic mv, input logic [63:0] mres,
                            input logic [4:0] mrd, input logic [3:0] cls, input logic fen,
                            input logic flush, input logic lv, input logic [63:0] lres,
                            input logic [4:0] lrd);
        logic exp_mrdy, exp_lrdy, fire, wr;
        @(negedge clk_sys_i);
        check_val("rf_wen", bus.rf_wen_o, e_wen);
        check_val("rf_addr", bus.rf_addr_o, e_addr);
        check_val("rf_data", bus.rf_data_o, e_data);
        check_val("fwd_ena", bus.fwd_ena_o, e_fen);
        check_val("fwd_addr", bus.fwd_addr_o, e_addr);
        check_val("fwd_data", bus.fwd_data_o, e_data);
        check_val("ecall", bus.ecall_o, e_ecall);
        check_val("ll_count", bus.ll_count_o, ll_q.size());

        rst_sys_n_i        = rst_n;
        bus.main_valid_i   = mv;
        bus.main_result_i  = mres;
        bus.main_rd_i      = mrd;
        bus.main_ctrl_i    = {1'($urandom), cls, 3'($urandom)};
        bus.main_fwd_ena_i = fen;
        bus.flush_i        = flush;
        bus.ll_valid_i     = lv;
        bus.ll_result_i    = lres;
        bus.ll_rd_i        = lrd;
        #1;
        exp_mrdy = rst_n && !(m_starve >= STARVE_LIMIT && ll_q.size() != 0);
        exp_lrdy = rst_n && (ll_q.size() < LL_DEPTH);
        check_val("main_ready", bus.main_ready_o, exp_mrdy);
        check_val("ll_ready", bus.ll_ready_o, exp_lrdy);

        fire = mv && exp_mrdy && !flush;
        last_main_acc = fire;
        last_ll_acc   = lv && exp_lrdy;
        if (!rst_n) begin
            ll_q.delete();
            m_starve = 0;
            {e_wen, e_fen, e_ecall, e_addr, e_data} = '0;
        end else begin
            wr = fire && class_writes(cls) && (mrd != 0);
            e_ecall = fire && (cls == 4'd13);
            if (wr) begin
                e_wen = 1; e_addr = mrd; e_data = mres; e_fen = fen;
                m_starve = (ll_q.size() == 0) ? 0 :
                           ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1);
            end else if (ll_q.size() != 0) begin
                logic [68:0] e;
                e = ll_q.pop_front();
                e_wen = 1; e_addr = e[68:64]; e_data = e[63:0]; e_fen = 1;
                m_starve = 0;
            end else begin
                e_wen = 0; e_fen = 0; m_starve = 0;
            end
            if (lv && exp_lrdy) ll_q.push_back({lrd, lres});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int ll_sent;
        int m_seq;
        rst_sys_n_i = 0;
        bus.main_valid_i = 0; bus.main_result_i = 0; bus.main_rd_i = 0;
        bus.main_ctrl_i = 0; bus.main_fwd_ena_i = 0; bus.flush_i = 0;
        bus.ll_valid_i = 0; bus.ll_result_i = 0; bus.ll_rd_i = 0;
        repeat (2) @(posedge clk_sys_i);
        do_cycle(0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);

        // ADD x5 = 0x1234 right after reset drops
        do_cycle(1, 1, 64'h1234, 5'd5, CTRL_ARITHMETIC_R_00, 1, 0, 0, 0, 0);
        idle(1);
        // store, branch, ADD to x0, then ECALL
        do_cycle(1, 1, 64'h11, 5'd3, CTRL_ACCESS_S, 1, 0, 0, 0, 0);
        do_cycle(1, 1, 64'h22, 5'd4, CTRL_BRANCH_B, 1, 0, 0, 0, 0);
        do_cycle(1, 1, 64'h33, 5'd0, CTRL_ARITHMETIC_R_00, 1, 0, 0, 0, 0);
        do_cycle(1, 1, 64'h44, 5'd6, CTRL_ECALL, 0, 0, 0, 0, 0);
        idle(2);
        // DIV x7 = 0xAA alongside a store
        do_cycle(1, 1, 64'h55, 5'd2, CTRL_ACCESS_S, 0, 0, 1, 64'hAA, 5'd7);
        do_cycle(1, 1, 64'h56, 5'd2, CTRL_ACCESS_S, 0, 0, 0, 0, 0);
        idle(2);

        // FIFO fill and starvation: main writes every cycle, five LL results held until taken
        ll_sent = 0; m_seq = 0;
        for (int c = 0; c < 40; c++) begin
            do_cycle(1, 1, 64'h1000 + 64'(m_seq), 5'(1 + m_seq % 31), CTRL_ARITHMETIC_I_0,
                     1'(m_seq), 0, ll_sent < 5, 64'hD000 + 64'(ll_sent), 5'(10 + ll_sent));
            if (last_main_acc) m_seq++;
            if (last_ll_acc) ll_sent++;
        end
        idle(6);

        // reset with three entries pending
        for (int c = 0; c < 3; c++)
            do_cycle(1, 1, 64'h2000 + 64'(c), 5'd9, CTRL_LUI, 0, 0, 1, 64'hE000 + 64'(c), 5'd12);
        do_cycle(0, 1, 64'h99, 5'd9, CTRL_LUI, 0, 0, 1, 64'h77, 5'd12);
        idle(4);
        // flushed ADD
        do_cycle(1, 1, 64'hBAD, 5'd8, CTRL_ARITHMETIC_R_00, 1, 1, 0, 0, 0);
        do_cycle(1, 1, 64'hBAD, 5'd8, CTRL_ECALL, 1, 1, 0, 0, 0);
        idle(2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            do_cycle(($urandom_range(0, 199) != 0), 1'($urandom), {$urandom, $urandom},
                     5'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 2) == 0), {$urandom, $urandom}, 5'($urandom));
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_arbiter_stage.md
Name: wb_arbiter_stage

Overview:
- Parametrised write-back stage. It merges the in-order pipeline result with results from long-latency units (MUL/DIV) onto the single register-file write port.
- The register-file write and the forwarding outputs are registered (1 cycle after acceptance).
- Long-latency results wait in an internal FIFO. A starvation counter guarantees that FIFO entries eventually drain.
- Sits between the MEM stage and the register file. It also feeds the WB forwarding path and the ECALL detector.

Parameters:
- XLEN, 64, data width of results and register-file write data.
- CTRL_W, 8, width of the control word; bits [6:3] carry the instruction class.
- LL_DEPTH, 4, long-latency FIFO depth; power of two, at least 2.
- STARVE_LIMIT, 8, number of consecutive main-channel writes allowed while the FIFO is non-empty; at least 1.

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_n_i  in  1  synchronous, active-low reset, sampled on the rising edge of clk_sys_i
- main_valid_i  in  1  pipeline result valid
- main_ready_o  out  1  stage accepts the pipeline result this cycle
- main_result_i  in  XLEN  pipeline result
- main_rd_i  in  5  destination register
- main_ctrl_i  in  CTRL_W  control word
- main_fwd_ena_i  in  1  MEM-stage forwarding enable, carried through to the WB forwarding outputs
- flush_i  in  1  kill the main-channel input this cycle
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept an entry
- ll_result_i  in  XLEN  long-latency result
- ll_rd_i  in  5  long-latency destination register
- rf_wen_o  out  1  register-file write enable
- rf_addr_o  out  5  register-file write address
- rf_data_o  out  XLEN  register-file write data
- fwd_ena_o  out  1  WB forwarding valid
- fwd_addr_o  out  5  WB forwarding address
- fwd_data_o  out  XLEN  WB forwarding data
- ecall_o  out  1  one-cycle pulse when an accepted main instruction is ECALL
- ll_count_o  out  $clog2(LL_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_sys_n_i low at a clock edge):
  - All registered outputs go to 0. FIFO pointers and count go to 0; starve counter goes to 0.
  - Any in-flight FIFO contents are discarded.
  - While reset is held, main_ready_o=0 and ll_ready_o=0.
- Write decode (per the shared package):
  - Write-enabled classes: ARITHMETIC_R_00/01/10, ARITHMETIC_I_0/1, ACCESS_I, JAL, JALR, LUI, AUIPC.
  - No write: ACCESS_S, BRANCH_B, CSR, ECALL, and any other class.
  - rd=0 never writes.
- Main acceptance:
  - main_fire = main_valid_i & main_ready_o & ~flush_i.
  - main_ready_o = ~starve, where starve = (starve_cnt == STARVE_LIMIT) & (count != 0).
- Port arbitration (decided combinationally, registered at the edge):
  - If main_fire and the decoded write is active, the main result owns the port.
  - Otherwise, if count != 0, the FIFO head is popped and owns the port.
  - A main instruction that is accepted but does not write (store, branch, rd=0) leaves the port free for a FIFO pop in the same cycle.
- Registered outputs, next edge after acceptance:
  - rf_wen_o, rf_addr_o, rf_data_o take the winning source.
  - fwd_addr_o, fwd_data_o equal rf_addr_o, rf_data_o.
  - fwd_ena_o = main_fwd_ena_i when main wins; 1 when the FIFO wins; 0 when idle.
  - When idle, rf_wen_o=0 and address/data hold their last values.
- ecall_o: registered pulse, set when main_fire and ctrl[6:3]==CTRL_ECALL.
- Starve counter:
  - Increments on each main write while count != 0.
  - Resets to 0 on any FIFO pop or when count == 0.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - push = ll_valid_i & ll_ready_o.
  - ll_ready_o = (count != LL_DEPTH), from registered count; no same-cycle pass-through when full.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo LL_DEPTH.
  - Pushing into an empty FIFO makes the entry eligible for a pop on the next cycle, giving a 2-cycle minimum latency from ll_valid_i to rf_wen_o.
- flush_i:
  - Suppresses main acceptance and ecall_o for that cycle.
  - Does not affect the FIFO or an already-registered write.
- Ordering hazards: the issue logic guarantees no WAW between the main and long-latency channels; this block does not check for it.

Decomposition:
- Shared package qiantang_pkg holds:
  - CTRL_* class encodings (4-bit)
  - REG_WIDTH default
  - function wb_writes(ctrl[6:3]) returning the write-enable decode
- One sub-module, wb_ll_fifo (parametrised XLEN+5 bits wide, LL_DEPTH deep), with push/pop/count/full/empty.
- Arbitration, starve logic and output registers stay in wb_arbiter_stage.

Test Plan:
- Reset drop: ADD x5=0x1234 with main_valid_i=1 → next cycle rf_wen_o=1, rf_addr_o=5, rf_data_o=0x1234, fwd_ena_o equals main_fwd_ena_i.
- Non-writing classes: store, then branch, then ADD to x0 → rf_wen_o stays 0 for all three. ECALL → ecall_o is a single 1-cycle pulse and rf_wen_o=0.
- Free-slot drain: push DIV x7=0xAA while main issues a store → x7=0xAA is written 2 cycles after ll_valid_i and ll_count_o returns to 0.
- FIFO fill: with main writing every cycle and STARVE_LIMIT=8, push 4 LL results → ll_ready_o=0 at count=4, and the fifth ll_valid_i is held without loss.
- Starvation: FIFO non-empty during 8 consecutive main writes → main_ready_o=0 for exactly 1 cycle, the FIFO head is written, then main resumes with the held instruction written once, not duplicated.
- Mid-operation reset and flush:
  - Assert reset with 3 FIFO entries → ll_count_o=0, all outputs 0, and no stale write after reset releases.
  - flush_i with a valid ADD → no write and no ecall_o.
